// File: rtl/maze_pkg.sv
// Shared constants and FSM encoding for the maze map writer and its helpers.
package maze_pkg;

  localparam int MAP_ROW_W  = 30;
  localparam int MAP_DEPTH  = 21;
  localparam int NUM_LEVELS = 3;

  // Levels are stored back-to-back in the level ROM.
  localparam int LVL0_BASE = 0 * MAP_DEPTH;
  localparam int LVL1_BASE = 1 * MAP_DEPTH;
  localparam int LVL2_BASE = 2 * MAP_DEPTH;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LOAD_RD = 5'b00010,
    LOAD_WR = 5'b00100,
    EDIT_RD = 5'b01000,
    EDIT_WR = 5'b10000
  } wr_state_e;

endpackage

// File: rtl/maze_map_writer_if.sv
// Memory-side bus of the maze map writer: level ROM read port and map RAM read/write ports.
interface maze_map_writer_if
  import maze_pkg::*;
#(
  parameter int ROW_W = MAP_ROW_W,
  parameter int ADDRW = $clog2(MAP_DEPTH),
  parameter int ROMAW = $clog2(MAP_DEPTH * NUM_LEVELS)
);
  logic [ROMAW-1:0] rom_addr;
  logic [ROW_W-1:0] rom_data;
  logic [ADDRW-1:0] ram_raddr;
  logic [ROW_W-1:0] ram_rdata;
  logic             ram_we;
  logic [ADDRW-1:0] ram_waddr;
  logic [ROW_W-1:0] ram_wdata;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_raddr,
    input  ram_rdata,
    output ram_we,
    output ram_waddr,
    output ram_wdata
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_raddr,
    output ram_rdata,
    input  ram_we,
    input  ram_waddr,
    input  ram_wdata
  );
endinterface

// File: rtl/maze_row_patch.sv
// Combinational bit replace: returns row_in with bit x forced to val.
module maze_row_patch
  import maze_pkg::*;
#(
  parameter int ROW_W = MAP_ROW_W
) (
  input  logic [ROW_W-1:0]         row_in,
  input  logic [$clog2(ROW_W)-1:0] x,
  input  logic                     val,
  output logic [ROW_W-1:0]         row_out
);
  logic [ROW_W-1:0] mask;

  // Build a one-hot mask at x and set or clear that bit.
  always_comb begin
    mask    = {{(ROW_W-1){1'b0}}, 1'b1} << x;
    row_out = val ? (row_in | mask) : (row_in & ~mask);
  end
endmodule

// File: rtl/maze_map_writer.sv
// Maze map writer: copies a level from the level ROM into map RAM and applies single-cell edits.
// Optional macro MAZE_MAP_WRITER_CHECKSUM_EN adds an XOR checksum of the rows written by a load.
module maze_map_writer
  import maze_pkg::*;
#(
  parameter int ROW_W  = MAP_ROW_W,
  parameter int DEPTH  = MAP_DEPTH,
  parameter int LEVELS = NUM_LEVELS,
  parameter int ADDRW  = $clog2(DEPTH),
  parameter int ROMAW  = $clog2(DEPTH * LEVELS),
  parameter int LVLW   = $clog2(LEVELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [LVLW-1:0]       load_level,
  input  logic                  edit_valid,
  output logic                  edit_ready,
  input  logic [7:0]            edit_x,
  input  logic [7:0]            edit_y,
  input  logic                  edit_val,
  maze_map_writer_if.master     mem,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err
`ifdef MAZE_MAP_WRITER_CHECKSUM_EN
  ,
  output logic [ROW_W-1:0]      checksum
`endif
);
  localparam int XW = $clog2(ROW_W);

  wr_state_e        state_r, state_nx;
  logic [ADDRW-1:0] row_r, row_nx;
  logic [ROMAW-1:0] base_r, base_nx;
  logic [XW-1:0]    ex_r, ex_nx;
  logic [ADDRW-1:0] ey_r, ey_nx;
  logic             ev_r, ev_nx;
  logic             load_done_nx, err_nx;

  logic [ROMAW-1:0] rom_addr_r;
  logic [ADDRW-1:0] ram_raddr_r;
  logic [ADDRW-1:0] ram_waddr_r;
  logic             ram_we_r, wr_load_r;
  logic             busy_r, ready_r, load_done_r, err_r;
  logic [ROW_W-1:0] patched;
  logic [ROW_W-1:0] wdata;

  maze_row_patch #(.ROW_W(ROW_W)) u_patch (
    .row_in  (mem.ram_rdata),
    .x       (ex_r),
    .val     (ev_r),
    .row_out (patched)
  );

  // Next-state and request decode; load wins over an edit in the same cycle.
  always_comb begin
    state_nx     = state_r;
    row_nx       = row_r;
    base_nx      = base_r;
    ex_nx        = ex_r;
    ey_nx        = ey_r;
    ev_nx        = ev_r;
    load_done_nx = 1'b0;
    err_nx       = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_start) begin
          if (32'(load_level) < LEVELS) begin
            base_nx  = ROMAW'(load_level) * ROMAW'(DEPTH);
            row_nx   = {ADDRW{1'b0}};
            state_nx = LOAD_RD;
          end else begin
            err_nx = 1'b1;
          end
        end else if (edit_valid && ready_r) begin
          if ((32'(edit_x) >= ROW_W) || (32'(edit_y) >= DEPTH)) begin
            err_nx = 1'b1;
          end else begin
            ex_nx    = edit_x[XW-1:0];
            ey_nx    = edit_y[ADDRW-1:0];
            ev_nx    = edit_val;
            state_nx = EDIT_RD;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD_RD: state_nx = LOAD_WR;
      LOAD_WR: begin
        if (row_r == ADDRW'(DEPTH - 1)) begin
          load_done_nx = 1'b1;
          state_nx     = IDLE;
        end else begin
          row_nx   = row_r + {{(ADDRW-1){1'b0}}, 1'b1};
          state_nx = LOAD_RD;
        end
      end
      EDIT_RD: state_nx = EDIT_WR;
      EDIT_WR: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      row_r       <= {ADDRW{1'b0}};
      base_r      <= {ROMAW{1'b0}};
      ex_r        <= {XW{1'b0}};
      ey_r        <= {ADDRW{1'b0}};
      ev_r        <= 1'b0;
      rom_addr_r  <= {ROMAW{1'b0}};
      ram_raddr_r <= {ADDRW{1'b0}};
      ram_waddr_r <= {ADDRW{1'b0}};
      ram_we_r    <= 1'b0;
      wr_load_r   <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      load_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      row_r       <= row_nx;
      base_r      <= base_nx;
      ex_r        <= ex_nx;
      ey_r        <= ey_nx;
      ev_r        <= ev_nx;
      rom_addr_r  <= (state_nx == LOAD_RD) ? (base_nx + ROMAW'(row_nx)) : {ROMAW{1'b0}};
      ram_raddr_r <= (state_nx == EDIT_RD) ? ey_nx : {ADDRW{1'b0}};
      ram_waddr_r <= (state_nx == LOAD_WR) ? row_nx :
                     (state_nx == EDIT_WR) ? ey_nx : {ADDRW{1'b0}};
      ram_we_r    <= (state_nx == LOAD_WR) || (state_nx == EDIT_WR);
      wr_load_r   <= (state_nx == LOAD_WR);
      busy_r      <= (state_nx != IDLE);
      ready_r     <= (state_nx == IDLE);
      load_done_r <= load_done_nx;
      err_r       <= err_nx;
    end
  end

  // ROM and RAM return data a cycle after their address, so write data passes
  // straight through under a registered select.
  always_comb begin
    wdata = {ROW_W{1'b0}};
    if (ram_we_r) begin
      wdata = wr_load_r ? mem.rom_data : patched;
    end else begin
      wdata = {ROW_W{1'b0}};
    end
  end

  assign mem.rom_addr  = rom_addr_r;
  assign mem.ram_raddr = ram_raddr_r;
  assign mem.ram_we    = ram_we_r;
  assign mem.ram_waddr = ram_waddr_r;
  assign mem.ram_wdata = wdata;
  assign edit_ready    = ready_r & ~load_start;
  assign busy          = busy_r;
  assign load_done     = load_done_r;
  assign err           = err_r;

`ifdef MAZE_MAP_WRITER_CHECKSUM_EN
  logic [ROW_W-1:0] checksum_r;

  // XOR of every row written by the current load; edits leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_r <= {ROW_W{1'b0}};
    end else if ((state_r == IDLE) && (state_nx == LOAD_RD)) begin
      checksum_r <= {ROW_W{1'b0}};
    end else if (state_r == LOAD_WR) begin
      checksum_r <= checksum_r ^ mem.rom_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif
endmodule

// File: tb/tb_maze_map_writer.sv
// Directed self-checking bench for maze_map_writer with behavioural level ROM and map RAM.
module tb_maze_map_writer;
  import maze_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [1:0]  load_level;
  logic        edit_valid;
  logic        edit_ready;
  logic [7:0]  edit_x;
  logic [7:0]  edit_y;
  logic        edit_val;
  logic        busy;
  logic        load_done;
  logic        err;
`ifdef MAZE_MAP_WRITER_CHECKSUM_EN
  logic [29:0] checksum;
`endif

  maze_map_writer_if #(.ROW_W(30), .ADDRW(5), .ROMAW(6)) mem ();

  maze_map_writer dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_level (load_level),
    .edit_valid (edit_valid),
    .edit_ready (edit_ready),
    .edit_x     (edit_x),
    .edit_y     (edit_y),
    .edit_val   (edit_val),
    .mem        (mem),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err)
`ifdef MAZE_MAP_WRITER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

  logic [29:0] ram [0:31];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_a = 5'd0;
  logic [29:0] poke_v = 30'd0;

  int          we_c[$];
  logic [4:0]  we_a[$];
  logic [29:0] we_d[$];
  int          done_c[$];
  int          err_c[$];
  int          nrdy_c[$];
  int          busy_n = 0;

  function automatic logic [29:0] rom_fn(input logic [5:0] a);
    if (rom_mode == 0) return 30'(a) ^ 30'h155;
    else if (a < 6'd21) return 30'd1 << a;
    else return 30'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous level ROM and map RAM, one cycle read latency each.
  always @(posedge clk) begin
    mem.rom_data  <= rom_fn(mem.rom_addr);
    mem.ram_rdata <= ram[mem.ram_raddr];
    if (mem.ram_we) ram[mem.ram_waddr] <= mem.ram_wdata;
    if (poke_en) ram[poke_a] <= poke_v;
  end

  always @(negedge clk) begin
    if (mem.ram_we) begin
      we_c.push_back(cyc);
      we_a.push_back(mem.ram_waddr);
      we_d.push_back(mem.ram_wdata);
    end
    if (load_done) done_c.push_back(cyc);
    if (err) err_c.push_back(cyc);
    if (!edit_ready) nrdy_c.push_back(cyc);
    if (busy) busy_n = busy_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr_logs();
    we_c.delete(); we_a.delete(); we_d.delete();
    done_c.delete(); err_c.delete(); nrdy_c.delete();
    busy_n = 0;
  endtask

  task automatic start_load(input int lvl);
    load_level = 2'(lvl);
    load_start = 1'b1;
    step(1);
    load_start = 1'b0;
  endtask

  task automatic check_load(input string tag, input int c0, input int lvl, input int total);
    chk({tag, "_we_n"}, we_c.size(), total);
    if (we_c.size() >= 21) begin
      for (int n = 0; n < 21; n++) begin
        chk({tag, "_addr"}, we_a[n], n);
        chk({tag, "_data"}, we_d[n], (lvl * 21 + n) ^ 32'h155);
        chk({tag, "_cyc"}, we_c[n], c0 + 2 + 2 * n);
      end
    end
    chk({tag, "_done_n"}, done_c.size(), 1);
    if (done_c.size() == 1) chk({tag, "_done_cyc"}, done_c[0], c0 + 43);
  endtask

  task automatic do_edit(input string tag, input int x, input int y, input int v,
                         input int exp_we, input logic [31:0] exp_d);
    int c;
    clr_logs();
    c = cyc;
    edit_x = 8'(x); edit_y = 8'(y); edit_val = v[0];
    edit_valid = 1'b1;
    #1 chk({tag, "_ready"}, edit_ready, 1);
    step(1);
    edit_valid = 1'b0;
    step(5);
    chk({tag, "_we_n"}, we_c.size(), exp_we);
    chk({tag, "_err_n"}, err_c.size(), (exp_we == 0) ? 1 : 0);
    if (exp_we == 1 && we_c.size() == 1) begin
      chk({tag, "_addr"}, we_a[0], y);
      chk({tag, "_data"}, we_d[0], exp_d);
      chk({tag, "_cyc"}, we_c[0], c + 2);
      chk({tag, "_nrdy_n"}, nrdy_c.size(), 2);
    end
    if (exp_we == 0 && err_c.size() == 1) begin
      chk({tag, "_err_cyc"}, err_c[0], c + 1);
      chk({tag, "_nrdy_n"}, nrdy_c.size(), 0);
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; load_start = 1'b0; load_level = 2'd0;
    edit_valid = 1'b0; edit_x = 8'd0; edit_y = 8'd0; edit_val = 1'b0;
    step(3);
    chk("rst_ram_we", mem.ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", edit_ready, 0);
    chk("rst_done_err", {load_done, err}, 0);
    chk("rst_addrs", {mem.rom_addr, mem.ram_raddr, mem.ram_waddr}, 0);
    chk("rst_wdata", mem.ram_wdata, 0);
    reset = 1'b0;
    step(3);

    // Level 1 load.
    clr_logs();
    c = cyc;
    load_level = 2'd1;
    load_start = 1'b1;
    #1 chk("load_ready_low", edit_ready, 0);
    step(1);
    load_start = 1'b0;
    step(48);
    check_load("l1", c, 1, 21);
    chk("l1_busy_cycles", busy_n, 42);

    // Edits on the loaded map, including boundaries.
    poke_en = 1'b1; poke_a = 5'd3; poke_v = 30'd0;
    step(1);
    poke_en = 1'b0;
    do_edit("ed_set", 5, 3, 1, 1, 32'h20);
    do_edit("ed_clr", 2, 20, 0, 1, 32'h178);
    do_edit("ed_x29", 29, 0, 1, 1, 32'h20000140);
    do_edit("ed_x30", 30, 3, 1, 0, 32'h0);
    do_edit("ed_y21", 3, 21, 1, 0, 32'h0);

    // Out-of-range level.
    clr_logs();
    c = cyc;
    start_load(3);
    step(5);
    chk("badlvl_we_n", we_c.size(), 0);
    chk("badlvl_err_n", err_c.size(), 1);
    if (err_c.size() == 1) chk("badlvl_err_cyc", err_c[0], c + 1);
    chk("badlvl_busy", busy_n, 0);

    // Load and edit in the same cycle: load first, edit after load_done.
    clr_logs();
    c = cyc;
    load_level = 2'd2; load_start = 1'b1;
    edit_x = 8'd7; edit_y = 8'd0; edit_val = 1'b1; edit_valid = 1'b1;
    #1 chk("both_ready_low", edit_ready, 0);
    step(1);
    load_start = 1'b0;
    step(43);
    edit_valid = 1'b0;
    step(5);
    check_load("l2", c, 2, 22);
    if (we_c.size() == 22) begin
      chk("l2_edit_cyc", we_c[21], c + 45);
      chk("l2_edit_addr", we_a[21], 0);
      chk("l2_edit_data", we_d[21], 32'h1FF);
    end

    // Asynchronous reset in the middle of row 10.
    clr_logs();
    c = cyc;
    start_load(0);
    step(21);
    chk("mid_we", mem.ram_we, 1);
    chk("mid_waddr", mem.ram_waddr, 10);
    reset = 1'b1;
    #1;
    chk("arst_we", mem.ram_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", edit_ready, 0);
    chk("arst_outs", {load_done, err, mem.rom_addr, mem.ram_raddr, mem.ram_waddr}, 0);
    chk("arst_wdata", mem.ram_wdata, 0);
    step(2);
    reset = 1'b0;
    step(5);
    chk("arst_no_done", done_c.size(), 0);
    chk("arst_we_n", we_c.size(), 10);
    clr_logs();
    c = cyc;
    start_load(0);
    step(47);
    check_load("l0", c, 0, 21);

`ifdef MAZE_MAP_WRITER_CHECKSUM_EN
    rom_mode = 1;
    clr_logs();
    c = cyc;
    start_load(0);
    step(42);
    chk("cks_done", load_done, 1);
    chk("cks_value", checksum, 32'h1FFFFF);
    step(3);
    do_edit("cks_ed", 4, 2, 1, 1, 32'h14);
    chk("cks_after_edit", checksum, 32'h1FFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_map_writer.md
Name: maze_map_writer

Overview:
- Writer end of the maze map memory interface; the collision logic is the reader.
- On a load request, copies one level's row words from a multi-level level ROM into the game's map RAM.
- Between loads, accepts single-cell edit requests (wall set/clear) and applies them as read-modify-write.
- Sits between the menu/difficulty FSM (which issues loads) and the map RAM (read by game logic and VGA).

Parameters:
- ROW_W, 30, bits per map row (one bit per cell, 1 = wall).
- DEPTH, 21, rows per level.
- LEVELS, 3, number of levels stored back-to-back in the level ROM.
- ADDRW, $clog2(DEPTH), map RAM row address width.
- ROMAW, $clog2(DEPTH*LEVELS), level ROM address width.
- LVLW, $clog2(LEVELS), level index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- load_start  in  1  single-cycle load request.
- load_level  in  LVLW  level to load, sampled with load_start.
- edit_valid  in  1  cell edit request valid.
- edit_ready  out  1  writer can accept an edit this cycle.
- edit_x  in  8  cell column.
- edit_y  in  8  cell row.
- edit_val  in  1  new cell value.
- rom_addr  out  ROMAW  level ROM address; ROM returns data 1 cycle later.
- rom_data  in  ROW_W  level ROM data.
- ram_raddr  out  ADDRW  map RAM read address; read data valid 1 cycle later.
- ram_rdata  in  ROW_W  map RAM read data.
- ram_we  out  1  map RAM write enable.
- ram_waddr  out  ADDRW  map RAM write address.
- ram_wdata  out  ROW_W  map RAM write data.
- busy  out  1  load or edit in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: all outputs 0, FSM state IDLE, row counter 0.
- Outputs are registered.
- FSM states: IDLE, LOAD_RD, LOAD_WR, EDIT_RD, EDIT_WR.
- edit_ready = (state == IDLE) && !load_start.
  - Load has priority over an edit in the same cycle.
  - An edit is accepted when edit_valid && edit_ready.
- Load acceptance: load_start in IDLE with load_level < LEVELS.
  - base = load_level*DEPTH; row = 0; next state LOAD_RD.
  - load_level >= LEVELS: no writes, err pulses the next cycle, stay IDLE.
- LOAD_RD: rom_addr = base + row; next state LOAD_WR.
- LOAD_WR: ram_we = 1, ram_waddr = row, ram_wdata = rom_data.
  - If row == DEPTH-1: load_done pulses the next cycle, return to IDLE.
  - Otherwise row++ and go to LOAD_RD.
- Load timing: exactly 2 cycles per row.
  - First ram_we occurs 2 cycles after acceptance.
  - DEPTH writes total, with row addresses 0..DEPTH-1 ascending.
- Edit acceptance: latch edit_x, edit_y, edit_val.
  - If edit_x >= ROW_W or edit_y >= DEPTH: no RAM access, err pulses the next cycle, return to IDLE.
  - Otherwise go to EDIT_RD.
- EDIT_RD: ram_raddr = edit_y; next state EDIT_WR.
- EDIT_WR: ram_we = 1, ram_waddr = edit_y, ram_wdata = ram_rdata with bit edit_x replaced by edit_val; return to IDLE.
- busy is high in every non-IDLE state.
- load_start, edit_valid and load_level are ignored while busy; no queuing.
- ram_we is never high in IDLE.
- ram_waddr is always < DEPTH.
- Reset mid-load: operation aborted and no load_done. The partially written RAM is the issuer's responsibility (reload required).

Optional Feature:
- Macro: MAZE_MAP_WRITER_CHECKSUM_EN.
- Enabled: adds output port checksum (ROW_W bits).
  - Cleared at load acceptance.
  - XOR-accumulates each ram_wdata written during a load.
  - Final value is stable from the load_done cycle until the next load acceptance.
  - Edits do not affect it. Reset clears it to 0.
- Disabled: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package maze_pkg: MAP_ROW_W=30, MAP_DEPTH=21, NUM_LEVELS=3, FSM state encoding (one-hot, 5 bits), level ROM base-address constants.
- Natural sub-module: maze_row_patch, a combinational bit-replace of row word at index x.
  - Reusable by any future trail/reveal writer.
- The FSM stays in maze_map_writer.

Test Plan:
- Reset, then load_start with level 1 and the ROM model returning (addr ^ 30'h155) → 21 writes, rows 0..20, each ram_wdata = (21+row) ^ 30'h155, first ram_we 2 cycles after start, load_done 1 cycle after the last write, busy high throughout.
- After a load, edit (x=5, y=3, val=1) with RAM row 3 = 0 → single write addr 3, data 30'h20; edit_ready low for 2 cycles.
- Edit x=30, y=3 → no ram_we, err pulse 1 cycle; likewise y=21; load_level=3 → err, no writes.
- load_start and edit_valid in the same IDLE cycle → load proceeds, edit_ready 0; the edit is accepted only after load_done.
- Reset asserted asynchronously during row 10 of a load → all outputs 0 immediately, no load_done; a subsequent load completes normally.
- With MAZE_MAP_WRITER_CHECKSUM_EN, level 0 where each row = 1<<row → checksum = 30'h1FFFFF at load_done; unchanged by a following edit.
